// File: rtl/placar_captura_if.sv
// placar_captura_if: pixel stream in, published digit patches out
interface placar_captura_if #(
    parameter int XW = 10
);
    logic                                 iFrameStart;
    logic                                 iValid;
    logic [XW-1:0]                        iX;
    logic [XW-1:0]                        iY;
    logic [7:0]                           iR;
    logic [7:0]                           iG;
    logic [7:0]                           iB;
    logic [7:1][3:1][10:0][10:0][7:0]     oNumero;
    logic                                 oValid;
    logic                                 oPulse;
    logic [7:0]                           oMiss;

    modport master (
        output iFrameStart, iValid, iX, iY, iR, iG, iB,
        input  oNumero, oValid, oPulse, oMiss
    );

    modport slave (
        input  iFrameStart, iValid, iX, iY, iR, iG, iB,
        output oNumero, oValid, oPulse, oMiss
    );
endinterface

// File: rtl/placar_captura.sv
// placar_captura: captures seven 11x11 RGB digit patches per frame and publishes them atomically
module placar_captura #(
    parameter int X0    = 560,
    parameter int Y0    = 20,
    parameter int PITCH = 12,
    parameter int XW    = 10
) (
    input logic          iCLK,
    input logic          iRST_N,
    placar_captura_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CAPTURE, PUBLISH} state_t;

    state_t                           state, state_nxt;
    logic [7:1][3:1][10:0][10:0][7:0] shadow;
    logic [XW:0]                      ry, dx;
    logic [3:0]                       row, col;
    logic [2:0]                       dig;
    logic                             hit, wr, term, publish, miss_inc;

    // Locate the pixel in one of the seven patches; the extra bit keeps pixels left of or above the window from wrapping into range
    always_comb begin
        ry  = {1'b0, bus.iY} - (XW+1)'(Y0);
        row = ry[3:0];
        dx  = '0;
        col = '0;
        dig = 3'd1;
        hit = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            dx = {1'b0, bus.iX} - (XW+1)'(X0 + (k - 1) * PITCH);
            if ({1'b0, bus.iX} >= (XW+1)'(X0 + (k - 1) * PITCH) && dx <= (XW+1)'(10)) begin
                hit = 1'b1;
                dig = 3'(k);
                col = dx[3:0];
            end
        end
        hit = hit && {1'b0, bus.iY} >= (XW+1)'(Y0) && ry <= (XW+1)'(10);
    end

    // Frame start takes effect before the pixel on the same cycle, so that pixel is already captured
    always_comb begin
        wr        = bus.iValid && hit && (state == CAPTURE || bus.iFrameStart);
        term      = wr && dig == 3'd7 && row == 4'd10 && col == 4'd10;
        miss_inc  = bus.iFrameStart && state == CAPTURE;
        publish   = state == PUBLISH;
        state_nxt = term ? PUBLISH : bus.iFrameStart ? CAPTURE : publish ? IDLE : state;
    end

    // State register
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) state <= IDLE;
        else         state <= state_nxt;
    end

    // Shadow capture, atomic publish (pulse aligned with the new data) and saturating miss count
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            shadow      <= '0;
            bus.oNumero <= '0;
            bus.oValid  <= 1'b0;
            bus.oPulse  <= 1'b0;
            bus.oMiss   <= '0;
        end else begin
            if (wr) begin
                shadow[dig][1][row][col] <= bus.iR;
                shadow[dig][2][row][col] <= bus.iG;
                shadow[dig][3][row][col] <= bus.iB;
            end
            if (publish) bus.oNumero <= shadow;
            if (publish) bus.oValid  <= 1'b1;
            bus.oPulse <= publish;
            if (miss_inc && bus.oMiss != 8'hFF) bus.oMiss <= bus.oMiss + 8'd1;
        end
    end
endmodule

// File: tb/tb_placar_captura.sv
// tb_placar_captura: directed frames with a pixel-level scoreboard checked on every publish strobe
module tb_placar_captura;
    typedef logic [7:1][3:1][10:0][10:0][7:0] img_t;
    typedef struct {
        img_t img;
        int   due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    placar_captura_if #(.XW(10)) bus();
    placar_captura #(.X0(560), .Y0(20), .PITCH(12), .XW(10)) dut (
        .iCLK   (clk),
        .iRST_N (rst_n),
        .bus    (bus)
    );

    exp_t q[$];
    exp_t mon_e;
    img_t model;
    bit   cap;
    bit   bad;
    int   br, bc;
    int   checks = 0, errors = 0, pulses = 0, cyc = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Every publish strobe must match the oldest pending expected image, two cycles after its terminal pixel
    always @(negedge clk) begin
        if (rst_n && bus.oPulse) begin
            pulses++;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse at cycle %0d", cyc);
            end else begin
                mon_e = q.pop_front();
                if (cyc != mon_e.due) begin
                    errors++;
                    $display("FAIL pulse_latency got cycle %0d expected %0d", cyc, mon_e.due);
                end
                for (int d = 1; d <= 7; d++) begin
                    for (int ch = 1; ch <= 3; ch++) begin
                        checks++;
                        if (bus.oNumero[d][ch] !== mon_e.img[d][ch]) begin
                            errors++;
                            bad = 1'b0;
                            br = 0;
                            bc = 0;
                            for (int r = 0; r <= 10; r++)
                                for (int c = 0; c <= 10; c++)
                                    if (!bad && bus.oNumero[d][ch][r][c] !== mon_e.img[d][ch][r][c]) begin
                                        bad = 1'b1;
                                        br = r;
                                        bc = c;
                                    end
                            $display("FAIL numero[%0d][%0d] row %0d col %0d got %0h expected %0h",
                                     d, ch, br, bc, bus.oNumero[d][ch][br][bc], mon_e.img[d][ch][br][bc]);
                        end
                    end
                end
            end
        end
    end

    task automatic pix(input int x, input int y, input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b, input logic v, input logic fs);
        int d, c;
        bus.iFrameStart = fs;
        bus.iValid      = v;
        bus.iX          = 10'(x);
        bus.iY          = 10'(y);
        bus.iR          = r;
        bus.iG          = g;
        bus.iB          = b;
        if (fs) cap = 1'b1;
        if (v && cap && y >= 20 && y <= 30 && x >= 560 && x <= 642 && (x - 560) % 12 <= 10) begin
            d = (x - 560) / 12 + 1;
            c = (x - 560) % 12;
            model[d][1][y-20][c] = r;
            model[d][2][y-20][c] = g;
            model[d][3][y-20][c] = b;
            if (d == 7 && y == 30 && c == 10) begin
                q.push_back('{model, cyc + 2});
                cap = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        bus.iFrameStart = 1'b0;
        bus.iValid      = 1'b0;
    endtask

    task automatic frame(input logic [7:0] bv, input int stop_row, input bit stop_term,
                         input int sx, input int sy, input logic [7:0] sr, input logic sv);
        pix(0, 0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        pix(100, 25, 8'hEE, 8'hEE, 8'hEE, 1'b1, 1'b0);
        for (int y = 18; y <= 31; y++) begin
            if (y == stop_row) return;
            for (int x = 556; x <= 646; x++) begin
                if (x == sx && y == sy) pix(x, y, sr, y[7:0], bv, sv, 1'b0);
                else                    pix(x, y, x[7:0], y[7:0], bv, 1'b1, 1'b0);
                if (stop_term && x == 642 && y == 30) return;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pulse_timeout got %0d pending expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        model = '0;
        cap = 1'b0;
        q.delete();
        #1;
        check("rst_valid", bus.oValid, 0);
        check("rst_pulse", bus.oPulse, 0);
        check("rst_miss", bus.oMiss, 0);
        check("rst_numero_zero", bus.oNumero == '0, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.iFrameStart = 1'b0;
        bus.iValid = 1'b0;
        bus.iX = '0;
        bus.iY = '0;
        bus.iR = '0;
        bus.iG = '0;
        bus.iB = '0;
        model = '0;
        cap = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("init_valid", bus.oValid, 0);
        check("init_pulse", bus.oPulse, 0);
        check("init_miss", bus.oMiss, 0);
        check("init_numero_zero", bus.oNumero == '0, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        frame(8'hA5, 999, 1'b0, -1, -1, 8'h00, 1'b1);
        drain();
        check("t1_pulses", pulses, 1);
        check("t1_r_1_0_0", bus.oNumero[1][1][0][0], 8'd48);
        check("t1_g_7_10_10", bus.oNumero[7][2][10][10], 8'd30);
        check("t1_b_4_5_5", bus.oNumero[4][3][5][5], 8'hA5);
        check("t1_valid", bus.oValid, 1);
        check("t1_miss", bus.oMiss, 0);

        frame(8'h3C, 25, 1'b0, -1, -1, 8'h00, 1'b1);
        frame(8'hC3, 999, 1'b0, -1, -1, 8'h00, 1'b1);
        drain();
        check("t2_pulses", pulses, 2);
        check("t2_miss", bus.oMiss, 1);
        check("t2_b_1_0_0", bus.oNumero[1][3][0][0], 8'hC3);
        check("t2_b_5_10_0", bus.oNumero[5][3][10][0], 8'hC3);

        frame(8'h5A, 999, 1'b0, 565, 22, 8'h77, 1'b1);
        drain();
        check("t3a_r_1_2_5", bus.oNumero[1][1][2][5], 8'h77);
        frame(8'h6B, 999, 1'b0, 565, 22, 8'h11, 1'b0);
        drain();
        check("t3_pulses", pulses, 4);
        check("t3_r_1_2_5_stale", bus.oNumero[1][1][2][5], 8'h77);
        check("t3_b_1_2_5_stale", bus.oNumero[1][3][2][5], 8'h5A);
        check("t3_r_1_2_6_new", bus.oNumero[1][1][2][6], 8'h36);
        check("t3_b_1_2_6_new", bus.oNumero[1][3][2][6], 8'h6B);

        do_reset();
        pix(0, 0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) begin
            pix(0, 0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
            pix(565, 22, 8'h99, 8'h99, 8'h99, 1'b1, 1'b0);
        end
        check("t4_miss_sat", bus.oMiss, 255);
        pix(0, 0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        pix(0, 0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        check("t4_miss_hold", bus.oMiss, 255);
        check("t4_valid", bus.oValid, 0);
        check("t4_pulses", pulses, 4);
        check("t4_numero_zero", bus.oNumero == '0, 1);

        frame(8'h21, 999, 1'b0, -1, -1, 8'h00, 1'b1);
        drain();
        check("t5a_valid", bus.oValid, 1);
        check("t5a_miss", bus.oMiss, 255);
        check("t5a_pulses", pulses, 5);
        frame(8'h22, 25, 1'b0, -1, -1, 8'h00, 1'b1);
        do_reset();
        frame(8'h23, 999, 1'b0, -1, -1, 8'h00, 1'b1);
        drain();
        check("t5_valid", bus.oValid, 1);
        check("t5_miss", bus.oMiss, 0);
        check("t5_pulses", pulses, 6);
        check("t5_b_2_3_4", bus.oNumero[2][3][3][4], 8'h23);

        frame(8'h31, 999, 1'b1, -1, -1, 8'h00, 1'b1);
        frame(8'h32, 999, 1'b0, -1, -1, 8'h00, 1'b1);
        drain();
        check("t6_pulses", pulses, 8);
        check("t6_miss", bus.oMiss, 0);
        check("t6_b_7_10_10", bus.oNumero[7][3][10][10], 8'h32);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
